// File: rtl/vec_mem_responder.sv
// vec_mem_responder: serialized scalar/vector load-store responder over a single-port synchronous-read memory
module vec_mem_responder #(
    parameter int registerSize = 16,
    parameter int vectorSize = 4,
    parameter int memDepth = 256
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_write,
    input  logic                                   req_vec,
    input  logic [15:0]                            req_addr,
    input  logic [vectorSize-1:0][registerSize-1:0] req_wdata,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [vectorSize-1:0][registerSize-1:0] rsp_rdata,
    output logic                                   rsp_err
);
    localparam int AW = $clog2(memDepth);
    localparam int LW = vectorSize > 1 ? $clog2(vectorSize) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;
    state_t state, state_n;
    logic write_q, vec_q, err_q, pend, accept, mem_en;
    logic [AW-1:0] addr_q, mem_idx;
    logic [vectorSize-1:0][registerSize-1:0] wdata_q;
    logic [LW-1:0] cnt, last, pend_lane;
    logic [registerSize-1:0] mem [memDepth];
    logic [registerSize-1:0] mem_q;
    assign req_ready = state == IDLE;
    assign accept = req_valid && req_ready;
    assign last = vec_q ? LW'(vectorSize - 1) : '0;
    assign mem_idx = addr_q + AW'(cnt);
    assign mem_en = reset && state == ACCESS && !err_q;
    // read-first single port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_en && write_q) mem[mem_idx] <= wdata_q[cnt];
        if (mem_en) mem_q <= mem[mem_idx];
    end
    always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? ACCESS : IDLE;
            ACCESS:  state_n = cnt == last ? DRAIN : ACCESS;
            DRAIN:   state_n = RESP;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // a lane read issued on one edge lands in rsp_rdata on the next
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            pend <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            pend <= state == ACCESS && !write_q && !err_q;
            pend_lane <= cnt;
            if (pend) rsp_rdata[pend_lane] <= mem_q;
            if (state == ACCESS) cnt <= cnt + 1'b1;
            if (accept) begin
                write_q <= req_write;
                vec_q <= req_vec;
                addr_q <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
                err_q <= ({1'b0, req_addr} + 17'(req_vec ? vectorSize : 1) - 17'd1) >= 17'(memDepth);
                cnt <= '0;
                rsp_rdata <= '0;
            end
            if (state == DRAIN) begin
                rsp_valid <= 1'b1;
                rsp_err <= err_q;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err <= 1'b0;
            end
        end
    end
endmodule
